alarm_sched: RTL
================

# alarm_sched

Alarm-output scheduler for the digital clock: arbitrates three alert requesters (alarm-time match, countdown-timer expiry, hourly chime) onto the single blinking alarm LED and buzzer enable. It sequences each alert's lifetime (ring, timeout, snooze, chime blink count) from the 1 Hz tick. It sits between the time-keeping/compare logic and the board LED/buzzer pins, and replaces free-running blink control with a single arbitrated state machine.

## Interface
- RING_SEC, 60: seconds a RING lasts before auto-stop (1..255).
- SNOOZE_SEC, 120: seconds spent in SNOOZE before re-ring (1..255).
- SNOOZE_MAX, 3: maximum snoozes per alarm event (0..7).
- clk  in  1  system clock; all logic on posedge.
- CLR_n  in  1  synchronous, active-high reset.
- one_HZ  in  1  one-clk-wide tick, once per second, synchronous to clk.
- alarm_req  in  1  one-clk pulse: alarm time matched.
- timer_req  in  1  one-clk pulse: countdown reached zero.
- chime_req  in  1  one-clk pulse: top of the hour.
- hour  in  5  current hour 0..23, sampled on chime_req.
- botton  in  1  one-clk pulse (debounced): stop/acknowledge.
- snooze  in  1  one-clk pulse (debounced): snooze request.
- led_alarm  out  1  alarm LED.
- buzz_en  out  1  buzzer enable, 1 only in RING.
- active_src  out  2  00 none, 01 alarm, 10 timer, 11 chime.
- snooze_cnt  out  3  snoozes used in the current alarm event.

## Operation
- Pending bits pend_alarm, pend_timer, pend_chime set on their request pulse. A request matching the source currently being serviced is dropped. The chime count is latched as N = hour mod 12, with 0 mapped to 12.
- States: IDLE, RING, SNOOZE, CHIME.
- IDLE: grant by fixed priority alarm > timer > chime. Clear the granted pending bit and load sec_cnt=0.
  - Alarm or timer grant: go to RING.
  - Chime grant: go to CHIME, with half_cnt=2N.
- RING: led toggles on every one_HZ. sec_cnt increments per tick. Exit conditions, highest priority first:
  - botton: go to IDLE; snooze_cnt cleared.
  - snooze, only when active_src=alarm and snooze_cnt<SNOOZE_MAX: go to SNOOZE with sec_cnt=0.
  - sec_cnt reaches RING_SEC: go to IDLE; snooze_cnt cleared.
- SNOOZE: led 0, buzz 0, active_src stays alarm.
  - botton: go to IDLE; snooze_cnt cleared.
  - sec_cnt reaches SNOOZE_SEC: go to RING; snooze_cnt+1.
- CHIME: led toggles on every one_HZ; half_cnt decrements per tick.
  - half_cnt reaches 0: go to IDLE.
  - botton: go to IDLE immediately.
  - pend_alarm set: abort the chime and go to RING/alarm next cycle. The chime is not resumed.
- Pending timer or chime requests raised during RING or SNOOZE wait for IDLE.
- Simultaneous events in one cycle:
  - botton beats snooze and beats one_HZ.
  - A request arriving in the same cycle as a grant is latched and serviced later.
  - Simultaneous requests in IDLE are served by priority; the others stay pending.

## Timing
- Reset values (CLR_n=1 at a clk edge): state IDLE, all pending bits 0, led_alarm 0, buzz_en 0, active_src 00, snooze_cnt 0, counters 0.
- Reset mid-operation aborts immediately; outputs return to reset values on the next edge.
- Request to grant: with the request latched at edge k, the state and active_src change at edge k+1. On that same edge led_alarm=1, and buzz_en=1 for RING.
- Exit to IDLE: led_alarm=0, buzz_en=0 and active_src=00 on the same edge as the state change. A pending request is granted on the following edge (one IDLE cycle minimum).
- LED duty: 1 s on / 1 s off, aligned to one_HZ. A chime of N produces exactly N on-pulses.
- Counters are 8-bit saturating compares; no wrap-around occurs inside valid parameter ranges.

## Configuration
- ALARM_SNOOZE_EN defined: SNOOZE state and snooze_cnt are implemented as described.
- ALARM_SNOOZE_EN undefined:
  - The snooze input is ignored and the SNOOZE state is never entered.
  - snooze_cnt is tied to 0.
  - RING ends only by botton or timeout.

## Test plan
- Reset, then alarm_req with RING_SEC=4 -> led 1,0,1,0 across ticks; buzz_en=1, active_src=01; back to IDLE after the 4th tick with led 0.
- chime_req with hour=15 -> CHIME with exactly 3 led on-pulses, then IDLE; hour=0 -> 12 pulses.
- alarm_req and timer_req on the same cycle -> alarm serviced first; botton -> one IDLE cycle, then RING with active_src=10.
- Alarm ring, snooze x3 with SNOOZE_SEC=2 -> re-ring after 2 ticks each time and snooze_cnt reaches 3; a 4th snooze is ignored (with ALARM_SNOOZE_EN). With the macro undefined, snooze never changes state.
- During CHIME (hour=5, after 2 pulses) alarm_req -> RING/alarm on the next edge, and the chime is discarded.
- CLR_n asserted mid-RING with botton and one_HZ also high -> all outputs at reset values next edge and pending bits cleared.

Source files
------------

// File: rtl/alarm_sched_if.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_sched_if
//  Brief    : Request/acknowledge inputs and LED/buzzer outputs of the alarm
//             scheduler. The board side drives requests through the master
//             modport, and the scheduler uses the slave modport.
//  Revision : 1.0  initial release
// ============================================================================
interface alarm_sched_if;
    logic       one_HZ;
    logic       alarm_req;
    logic       timer_req;
    logic       chime_req;
    logic [4:0] hour;
    logic       botton;
    logic       snooze;
    logic       led_alarm;
    logic       buzz_en;
    logic [1:0] active_src;
    logic [2:0] snooze_cnt;

    modport master (
        output one_HZ, alarm_req, timer_req, chime_req, hour, botton, snooze,
        input  led_alarm, buzz_en, active_src, snooze_cnt
    );

    modport slave (
        input  one_HZ, alarm_req, timer_req, chime_req, hour, botton, snooze,
        output led_alarm, buzz_en, active_src, snooze_cnt
    );
endinterface
`default_nettype wire

// File: rtl/alarm_sched.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_sched
//  Brief    : Arbitrates alarm / timer / hourly-chime alerts onto one blinking
//             LED and a buzzer enable. Sequences ring timeout, snooze and the
//             chime blink count from the 1 Hz tick.
//  Options  : ALARM_SNOOZE_EN - when defined, the SNOOZE state and snooze_cnt
//             are implemented; otherwise snooze is ignored and snooze_cnt = 0.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_sched #(
    parameter int unsigned RING_SEC   = 60,
    parameter int unsigned SNOOZE_SEC = 120,
    parameter int unsigned SNOOZE_MAX = 3
) (
    input  wire logic    clk,
    input  wire logic    CLR_n,
    alarm_sched_if.slave bus
);

    localparam logic [1:0] c_S_IDLE   = 2'd0;
    localparam logic [1:0] c_S_RING   = 2'd1;
    localparam logic [1:0] c_S_SNOOZE = 2'd2;
    localparam logic [1:0] c_S_CHIME  = 2'd3;

    localparam logic [7:0] c_RING_SEC   = 8'(RING_SEC);
    localparam logic [7:0] c_SNOOZE_SEC = 8'(SNOOZE_SEC);

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic       r_pend_alarm;
    logic       r_pend_timer;
    logic       r_pend_chime;
    logic [3:0] r_chime_n;
    logic [7:0] r_sec_cnt;
    logic [4:0] r_half_cnt;
    logic       r_led;
    logic       r_src_timer;
    logic [2:0] w_snooze_cnt;

    logic       w_clr_alarm;
    logic       w_clr_timer;
    logic       w_clr_chime;
    logic [7:0] w_sec_inc;
    logic       w_ring_done;
    logic       w_snz_done;
    logic       w_snooze_ok;
    logic       w_serv_alarm;
    logic       w_serv_timer;
    logic       w_serv_chime;
    logic [3:0] w_hour_n;

    // Seconds counter saturates rather than wrapping.
    assign w_sec_inc    = (r_sec_cnt == 8'hFF) ? 8'hFF : r_sec_cnt + 8'd1;
    assign w_ring_done  = (w_sec_inc >= c_RING_SEC);
    assign w_snz_done   = (w_sec_inc >= c_SNOOZE_SEC);

    // A new request for the source already being serviced is dropped.
    assign w_serv_alarm = ((r_state == c_S_RING) || (r_state == c_S_SNOOZE)) && !r_src_timer;
    assign w_serv_timer = (r_state == c_S_RING) && r_src_timer;
    assign w_serv_chime = (r_state == c_S_CHIME);

`ifdef ALARM_SNOOZE_EN
    localparam logic [2:0] c_SNOOZE_MAX = 3'(SNOOZE_MAX);
    logic [2:0] r_snooze_cnt;

    assign w_snooze_ok  = bus.snooze && !r_src_timer && (r_snooze_cnt < c_SNOOZE_MAX);
    assign w_snooze_cnt = r_snooze_cnt;

    // Snooze count: cleared whenever the alarm event ends, bumped on each re-ring.
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            r_snooze_cnt <= 3'd0;
        end else if ((w_state_nxt == c_S_IDLE) && (r_state != c_S_IDLE)) begin
            r_snooze_cnt <= 3'd0;
        end else if ((r_state == c_S_SNOOZE) && (w_state_nxt == c_S_RING)) begin
            r_snooze_cnt <= r_snooze_cnt + 3'd1;
        end
    end
`else
    logic w_unused_snooze;

    assign w_snooze_ok     = 1'b0;
    assign w_snooze_cnt    = 3'd0;
    assign w_unused_snooze = ^{bus.snooze, SNOOZE_MAX[2:0]};
`endif

    // Chime count is the 12-hour dial value: hour mod 12 with 0 shown as 12.
    always_comb begin
        if (bus.hour >= 5'd24) begin
            w_hour_n = 4'(bus.hour - 5'd24);
        end else if (bus.hour >= 5'd12) begin
            w_hour_n = 4'(bus.hour - 5'd12);
        end else begin
            w_hour_n = bus.hour[3:0];
        end
        if (w_hour_n == 4'd0) begin
            w_hour_n = 4'd12;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state and grant decisions; botton always wins over snooze and tick.
    always_comb begin
        w_state_nxt = r_state;
        w_clr_alarm = 1'b0;
        w_clr_timer = 1'b0;
        w_clr_chime = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (r_pend_alarm) begin
                    w_state_nxt = c_S_RING;
                    w_clr_alarm = 1'b1;
                end else if (r_pend_timer) begin
                    w_state_nxt = c_S_RING;
                    w_clr_timer = 1'b1;
                end else if (r_pend_chime) begin
                    w_state_nxt = c_S_CHIME;
                    w_clr_chime = 1'b1;
                end
            end
            c_S_RING: begin
                if (bus.botton) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_snooze_ok) begin
                    w_state_nxt = c_S_SNOOZE;
                end else if (bus.one_HZ && w_ring_done) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            c_S_SNOOZE: begin
                if (bus.botton) begin
                    w_state_nxt = c_S_IDLE;
                end else if (bus.one_HZ && w_snz_done) begin
                    w_state_nxt = c_S_RING;
                end
            end
            default: begin
                // CHIME: an alarm aborts the chime outright; it is not resumed.
                if (bus.botton) begin
                    w_state_nxt = c_S_IDLE;
                end else if (r_pend_alarm) begin
                    w_state_nxt = c_S_RING;
                    w_clr_alarm = 1'b1;
                end else if (bus.one_HZ && (r_half_cnt <= 5'd1)) begin
                    w_state_nxt = c_S_IDLE;
                end
            end
        endcase
    end

    // Pending bits, counters, LED phase and ring source.
    always_ff @(posedge clk) begin
        if (CLR_n) begin
            r_pend_alarm <= 1'b0;
            r_pend_timer <= 1'b0;
            r_pend_chime <= 1'b0;
            r_chime_n    <= 4'd0;
            r_sec_cnt    <= 8'd0;
            r_half_cnt   <= 5'd0;
            r_led        <= 1'b0;
            r_src_timer  <= 1'b0;
        end else begin
            // A request landing on its own grant cycle stays latched.
            r_pend_alarm <= (r_pend_alarm & ~w_clr_alarm) | (bus.alarm_req & ~w_serv_alarm);
            r_pend_timer <= (r_pend_timer & ~w_clr_timer) | (bus.timer_req & ~w_serv_timer);
            r_pend_chime <= (r_pend_chime & ~w_clr_chime) | (bus.chime_req & ~w_serv_chime);
            if (bus.chime_req && !w_serv_chime) begin
                r_chime_n <= w_hour_n;
            end
            if (w_state_nxt != r_state) begin
                r_sec_cnt <= 8'd0;
                r_led     <= (w_state_nxt == c_S_RING) || (w_state_nxt == c_S_CHIME);
                if (w_state_nxt == c_S_CHIME) begin
                    r_half_cnt <= {r_chime_n, 1'b0};
                end
                if (w_clr_alarm) begin
                    r_src_timer <= 1'b0;
                end else if (w_clr_timer) begin
                    r_src_timer <= 1'b1;
                end
            end else if (bus.one_HZ) begin
                if ((r_state == c_S_RING) || (r_state == c_S_SNOOZE)) begin
                    r_sec_cnt <= w_sec_inc;
                end
                if ((r_state == c_S_RING) || (r_state == c_S_CHIME)) begin
                    r_led <= ~r_led;
                end
                if ((r_state == c_S_CHIME) && (r_half_cnt != 5'd0)) begin
                    r_half_cnt <= r_half_cnt - 5'd1;
                end
            end
        end
    end

    // Outputs decoded from the registered state.
    always_comb begin
        bus.led_alarm  = r_led;
        bus.buzz_en    = (r_state == c_S_RING);
        bus.snooze_cnt = w_snooze_cnt;
        case (r_state)
            c_S_IDLE:   bus.active_src = 2'b00;
            c_S_CHIME:  bus.active_src = 2'b11;
            default:    bus.active_src = r_src_timer ? 2'b10 : 2'b01;
        endcase
    end

endmodule
`default_nettype wire
